// File: rtl/control_pipe.sv
// Decode-stage control: opcode -> registered 9-bit control word + ALU op, one-cycle latency into ID/EX.
// Stall (combinational) holds PC and IF/ID on load-use hazards and while a multi-cycle MUL occupies decode.
module control_pipe #(
    parameter int OPCODE_W    = 6,
    parameter int REG_W       = 5,
    parameter int MUL_LATENCY = 4,
    parameter int ILL_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [REG_W-1:0]     rs,
    input  logic [REG_W-1:0]     rt,
    input  logic                 ex_mem_read,
    input  logic [REG_W-1:0]     ex_rt,
    input  logic                 flush,
    output logic [8:0]           ctrl_bits,
    output logic [1:0]           alu_op,
    output logic                 ctrl_valid,
    output logic                 stall,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    localparam int CNT_W     = $clog2(MUL_LATENCY + 1);
    localparam bit MUL_MULTI = (MUL_LATENCY > 1);

    typedef enum logic {S_RUN, S_MUL_BUSY} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [8:0]           r_ctrl_bits;
    logic [1:0]           r_alu_op;
    logic                 r_ctrl_valid;
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    logic [31:0]          w_op32;
    logic [8:0]           w_dec_bits;
    logic [1:0]           w_dec_alu;
    logic                 w_legal;
    logic                 w_uses_rt;
    logic                 w_is_mul;
    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_issue;

    assign w_op32 = 32'(opcode);

    always_comb begin
        w_dec_bits = 9'b000000000;
        w_dec_alu  = 2'b00;
        w_legal    = 1'b1;
        w_uses_rt  = 1'b0;
        w_is_mul   = 1'b0;
        case (w_op32)
            32'h00: begin w_dec_bits = 9'b100000100; w_uses_rt = 1'b1; end
            32'h01: begin w_dec_bits = 9'b100000100; w_dec_alu = 2'b01; w_uses_rt = 1'b1; end
            32'h02: begin
                w_dec_bits = 9'b100000100; w_dec_alu = 2'b10; w_uses_rt = 1'b1; w_is_mul = 1'b1;
            end
            32'h10: w_dec_bits = 9'b001101100;
            32'h11: w_dec_bits = 9'b001101101;
            32'h12: begin w_dec_bits = 9'b000011000; w_uses_rt = 1'b1; end
            32'h13: begin w_dec_bits = 9'b000011001; w_uses_rt = 1'b1; end
            32'h30: begin w_dec_bits = 9'b010000000; w_dec_alu = 2'b01; w_uses_rt = 1'b1; end
            32'h31: w_dec_bits = 9'b010000010;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_hazard = instr_valid & ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == rs) | (w_uses_rt & (ex_rt == rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!flush && instr_valid && !w_hazard && w_is_mul && MUL_MULTI) begin
                    w_state_nxt = S_MUL_BUSY;
                    w_cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
                end
            end
            S_MUL_BUSY: begin
                if (flush) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt == CNT_W'(1)) w_state_nxt = S_RUN;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Hazards are ignored while busy: the decode slot is already being held.
    always_comb begin
        w_stall = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            S_RUN: begin
                w_stall = !flush && instr_valid && w_hazard;
                w_issue = !flush && instr_valid && !w_hazard;
            end
            S_MUL_BUSY: w_stall = !flush;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_bits  <= '0;
            r_alu_op     <= '0;
            r_ctrl_valid <= 1'b0;
            r_illegal    <= 1'b0;
            r_ill_cnt    <= '0;
        end else begin
            r_ctrl_bits  <= w_issue ? w_dec_bits : 9'b000000000;
            r_alu_op     <= w_issue ? w_dec_alu : 2'b00;
            r_ctrl_valid <= w_issue & w_legal;
            r_illegal    <= w_issue & ~w_legal;
            if (w_issue && !w_legal && !(&r_ill_cnt)) r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

    assign ctrl_bits     = r_ctrl_bits;
    assign alu_op        = r_alu_op;
    assign ctrl_valid    = r_ctrl_valid;
    assign illegal       = r_illegal;
    assign illegal_count = r_ill_cnt;
    assign stall         = w_stall & ~reset;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: two instances (MUL_LATENCY=4/ILL_CNT_W=8 and MUL_LATENCY=1/ILL_CNT_W=2) share stimulus.
module tb_control_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, instr_valid, ex_mem_read, flush;
    logic [5:0] opcode;
    logic [4:0] rs, rt, ex_rt;

    logic [8:0] a_bits, b_bits;
    logic [1:0] a_alu, b_alu;
    logic       a_vld, b_vld, a_stall, b_stall, a_ill, b_ill;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    control_pipe #(.OPCODE_W(6), .REG_W(5), .MUL_LATENCY(4), .ILL_CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
        .ctrl_bits(a_bits), .alu_op(a_alu), .ctrl_valid(a_vld), .stall(a_stall),
        .illegal(a_ill), .illegal_count(a_cnt));

    control_pipe #(.OPCODE_W(6), .REG_W(5), .MUL_LATENCY(1), .ILL_CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
        .ctrl_bits(b_bits), .alu_op(b_alu), .ctrl_valid(b_vld), .stall(b_stall),
        .illegal(b_ill), .illegal_count(b_cnt));

    typedef struct {
        logic [5:0] op;
        logic [8:0] bits;
        logic [1:0] alu;
        bit         legal;
        bit         uses_rt;
    } dec_t;

    typedef struct {
        logic [8:0] bits;
        logic [1:0] alu;
        bit         vld;
        bit         ill;
        int         cnt;
    } exp_t;

    localparam int NTBL = 12;
    dec_t tbl [NTBL];
    exp_t sbq [$];

    int checks   = 0;
    int failures = 0;
    int m_st  [2];
    int m_cnt [2];
    int m_ill [2];
    int sa, sb;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic lookup(input logic [5:0] op, output logic [8:0] b, output logic [1:0] a,
                          output bit lg, output bit ur);
        b = '0; a = '0; lg = 0; ur = 0;
        for (int i = 0; i < NTBL; i++)
            if (tbl[i].op == op) begin
                b = tbl[i].bits; a = tbl[i].alu; lg = tbl[i].legal; ur = tbl[i].uses_rt;
            end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_cnt[m] = 0; m_ill[m] = 0;
        end
        sbq.delete();
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit v, input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                        input bit exr, input logic [4:0] ext, input bit fl);
        logic [8:0] b;
        logic [1:0] a;
        bit lg, ur, hz, iss, ismul;
        bit es [2];
        int ml, cmax;
        exp_t e;
        instr_valid = v; opcode = op; rs = s; rt = t; ex_mem_read = exr; ex_rt = ext; flush = fl;
        lookup(op, b, a, lg, ur);
        hz    = v && exr && (ext != 0) && ((ext == s) || (ur && (ext == t)));
        ismul = (op == 6'h02);
        for (int m = 0; m < 2; m++) begin
            ml   = (m == 0) ? 4 : 1;
            cmax = (m == 0) ? 255 : 3;
            if (m_st[m] == 0) begin
                es[m] = !fl && v && hz;
                iss   = !fl && v && !hz;
                if (iss && ismul && ml > 1) begin m_st[m] = 1; m_cnt[m] = ml - 1; end
            end else begin
                es[m] = !fl;
                iss   = 0;
                if (fl) begin m_st[m] = 0; m_cnt[m] = 0; end
                else begin
                    if (m_cnt[m] == 1) m_st[m] = 0;
                    m_cnt[m]--;
                end
            end
            e.bits = iss ? b : 9'b0;
            e.alu  = iss ? a : 2'b0;
            e.vld  = iss && lg;
            e.ill  = iss && !lg;
            if (e.ill && m_ill[m] < cmax) m_ill[m]++;
            e.cnt  = m_ill[m];
            sbq.push_back(e);
        end
        #1;
        check("stall_a", 32'(a_stall), 32'(es[0]));
        check("stall_b", 32'(b_stall), 32'(es[1]));
        if (a_stall) sa++;
        if (b_stall) sb++;
        @(posedge clk); #1;
        if (sbq.size() < 2) begin
            check("scoreboard_depth", 32'(sbq.size()), 32'd2);
        end else begin
            e = sbq.pop_front();
            check("ctrl_bits_a", 32'(a_bits), 32'(e.bits));
            check("alu_op_a",    32'(a_alu),  32'(e.alu));
            check("ctrl_valid_a",32'(a_vld),  32'(e.vld));
            check("illegal_a",   32'(a_ill),  32'(e.ill));
            check("ill_count_a", 32'(a_cnt),  32'(e.cnt));
            e = sbq.pop_front();
            check("ctrl_bits_b", 32'(b_bits), 32'(e.bits));
            check("alu_op_b",    32'(b_alu),  32'(e.alu));
            check("ctrl_valid_b",32'(b_vld),  32'(e.vld));
            check("illegal_b",   32'(b_ill),  32'(e.ill));
            check("ill_count_b", 32'(b_cnt),  32'(e.cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_bits",  32'(a_bits),  32'd0);
        check("rst_vld",   32'(a_vld),   32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_cnt",   32'(a_cnt),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{6'h00, 9'b100000100, 2'b00, 1, 1};
        tbl[1]  = '{6'h01, 9'b100000100, 2'b01, 1, 1};
        tbl[2]  = '{6'h02, 9'b100000100, 2'b10, 1, 1};
        tbl[3]  = '{6'h10, 9'b001101100, 2'b00, 1, 0};
        tbl[4]  = '{6'h11, 9'b001101101, 2'b00, 1, 0};
        tbl[5]  = '{6'h12, 9'b000011000, 2'b00, 1, 1};
        tbl[6]  = '{6'h13, 9'b000011001, 2'b00, 1, 1};
        tbl[7]  = '{6'h30, 9'b010000000, 2'b01, 1, 1};
        tbl[8]  = '{6'h31, 9'b010000010, 2'b00, 1, 0};
        tbl[9]  = '{6'h03, 9'b000000000, 2'b00, 0, 0};
        tbl[10] = '{6'h20, 9'b000000000, 2'b00, 0, 0};
        tbl[11] = '{6'h3F, 9'b000000000, 2'b00, 0, 0};

        instr_valid = 0; opcode = '0; rs = '0; rt = '0; ex_mem_read = 0; ex_rt = '0; flush = 0;
        reset = 1'b1;
        do_reset();

        // Basic ADD
        step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 0);
        check("add_bits",  32'(a_bits),  32'(9'b100000100));
        check("add_valid", 32'(a_vld),   32'd1);

        // Whole decode table, each followed by idle cycles to drain a MUL
        for (int i = 0; i < NTBL; i++) begin
            step(1, tbl[i].op, 5'd1, 5'd2, 0, 5'd0, 0);
            check("tbl_bits", 32'(a_bits), 32'(tbl[i].bits));
            check("tbl_alu",  32'(a_alu),  32'(tbl[i].alu));
            idle(4);
        end

        // Load-use hazard on rs: exactly one stall cycle
        sa = 0;
        step(1, 6'h11, 5'd0, 5'd5, 0, 5'd0, 0);
        step(1, 6'h00, 5'd5, 5'd1, 1, 5'd5, 0);
        step(1, 6'h00, 5'd5, 5'd1, 0, 5'd0, 0);
        check("hazard_stalls", 32'(sa), 32'd1);
        check("hazard_issue",  32'(a_vld), 32'd1);
        // ex_rt=0 never hazards; LDB does not read rt
        sa = 0;
        step(1, 6'h00, 5'd0, 5'd0, 1, 5'd0, 0);
        step(1, 6'h10, 5'd1, 5'd7, 1, 5'd7, 0);
        step(1, 6'h12, 5'd1, 5'd7, 1, 5'd7, 0);
        step(1, 6'h12, 5'd1, 5'd7, 0, 5'd0, 0);
        check("hazard_rt_stalls", 32'(sa), 32'd1);

        // MUL occupancy
        sa = 0; sb = 0;
        step(1, 6'h02, 5'd1, 5'd2, 0, 5'd0, 0);
        check("mul_valid", 32'(a_vld), 32'd1);
        check("mul_alu",   32'(a_alu), 32'(2'b10));
        idle(4);
        check("mul_stalls_lat4", 32'(sa), 32'd3);
        check("mul_stalls_lat1", 32'(sb), 32'd0);

        // Illegal counting and saturation
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 6'h3F, 5'd0, 5'd0, 0, 5'd0, 0);
        check("ill_cnt3_a", 32'(a_cnt), 32'd3);
        for (int k = 0; k < 3; k++) step(1, 6'h3F, 5'd0, 5'd0, 0, 5'd0, 0);
        check("ill_cnt6_a",   32'(a_cnt), 32'd6);
        check("ill_sat_b",    32'(b_cnt), 32'd3);
        idle(1);
        check("ill_pulse_end", 32'(a_ill), 32'd0);

        // Flush in second busy cycle, then STW
        sa = 0;
        step(1, 6'h02, 5'd1, 5'd2, 0, 5'd0, 0);
        idle(1);
        step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 1);
        check("flush_stalls", 32'(sa), 32'd1);
        step(1, 6'h13, 5'd3, 5'd4, 0, 5'd0, 0);
        check("stw_bits", 32'(a_bits), 32'(9'b000011001));

        // Asynchronous reset mid-MUL_BUSY
        step(1, 6'h02, 5'd1, 5'd2, 0, 5'd0, 0);
        step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0);
        #1;
        check("busy_stall_pre", 32'(a_stall), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_stall", 32'(a_stall), 32'd0);
        check("arst_bits",  32'(a_bits),  32'd0);
        check("arst_vld",   32'(a_vld),   32'd0);
        check("arst_cnt",   32'(a_cnt),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        step(1, 6'h30, 5'd1, 5'd2, 0, 5'd0, 0);
        check("beq_bits", 32'(a_bits), 32'(9'b010000000));
        check("beq_alu",  32'(a_alu),  32'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Parametrised, registered successor to the decode-stage control decoder. It turns the IF/ID opcode into the 9-bit control word plus a 2-bit ALU op, and registers both into the ID/EX boundary.
- It also owns decode-side pipeline control:
  - load-use hazard stall
  - multi-cycle MUL occupancy stall (configurable latency)
  - flush handling
  - illegal-opcode flagging and counting
- Sits between if_id and id_ex in the decode stage.

Parameters:
- OPCODE_W, 6: opcode field width. Opcodes are compared zero-extended.
- REG_W, 5: register-specifier width.
- MUL_LATENCY, 4: total cycles a MUL occupies decode. Legal range 1..16.
- ILL_CNT_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  IF/ID holds a real instruction
- opcode  in  OPCODE_W  instruction[31:26]
- rs  in  REG_W  source register 1
- rt  in  REG_W  source register 2 / load destination
- ex_mem_read  in  1  memRead of the instruction currently in ID/EX
- ex_rt  in  REG_W  rt of the instruction currently in ID/EX
- flush  in  1  squash the decode slot (taken branch/jump)
- ctrl_bits  out  9  registered {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, jump, word}; bit 8 = regDst, bit 0 = word
- alu_op  out  2  registered: 00 add, 01 sub, 10 mul, 11 reserved
- ctrl_valid  out  1  registered: ctrl_bits describe a real instruction
- stall  out  1  combinational: hold PC and IF/ID this cycle
- illegal  out  1  registered one-cycle pulse for an unknown opcode
- illegal_count  out  ILL_CNT_W  saturating count of illegal opcodes

Behaviour:
- Reset (async): ctrl_bits=0, alu_op=00, ctrl_valid=0, illegal=0, illegal_count=0, state=RUN, busy counter=0. stall is 0 while reset is asserted.
- Decode table (ctrl_bits as binary, bit 8 first; alu_op):
  - 0x00 ADD: 100000100; 00
  - 0x01 SUB: 100000100; 01
  - 0x02 MUL: 100000100; 10
  - 0x10 LDB: 001101100; 00
  - 0x11 LDW: 001101101; 00
  - 0x12 STB: 000011000; 00
  - 0x13 STW: 000011001; 00
  - 0x30 BEQ: 010000000; 01
  - 0x31 JUMP: 010000010; 00
  - any other opcode: 000000000; 00, flagged illegal
- uses_rt is true for ADD, SUB, MUL, STB, STW, BEQ.
- Load-use hazard: hazard = instr_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == rs) | (uses_rt & ex_rt == rt)).
- States: RUN and MUL_BUSY.
- RUN, in priority order:
  - flush=1: next cycle ctrl_valid=0, ctrl_bits=0; stall=0; stay in RUN.
  - instr_valid=0: bubble (ctrl_valid=0, ctrl_bits=0); stall=0.
  - hazard=1: stall=1 this cycle; bubble registered; instruction re-presented next cycle.
  - Otherwise: decoded word registered, ctrl_valid=1 next cycle.
    - Illegal opcode: ctrl_valid=0, illegal=1 next cycle, illegal_count incremented (saturates at all-ones).
    - MUL with MUL_LATENCY>1: busy counter loads MUL_LATENCY-1; go to MUL_BUSY.
- MUL_BUSY:
  - stall=1 and bubble registered every cycle; counter decrements.
  - When counter==1, return to RUN next cycle.
  - A MUL therefore produces 1 valid cycle followed by MUL_LATENCY-1 bubble cycles, with stall high during those MUL_LATENCY-1 cycles.
  - flush in MUL_BUSY: go to RUN, clear counter, stall=0 that cycle, bubble registered. The MUL already issued is not recalled.
- MUL_LATENCY=1: MUL behaves like ADD; MUL_BUSY is never entered.
- illegal is 0 on every cycle not described above. illegal_count never wraps.
- Reset asserted mid-MUL_BUSY returns to RUN immediately, and stall drops to 0 asynchronously.
- hazard is ignored in MUL_BUSY, since the decode slot is already held.

Test Plan:
- Reset, then ADD (0x00) valid -> next cycle ctrl_bits=100000100, alu_op=00, ctrl_valid=1, stall=0.
- LDW with ex_mem_read=1, ex_rt=5, then ADD with rs=5 -> stall=1 for exactly one cycle with a bubble; ADD issues the following cycle. Repeating with ex_rt=0 -> no stall.
- MUL with MUL_LATENCY=4 -> ctrl_valid=1 for 1 cycle, then stall=1 with ctrl_valid=0 for 3 cycles, then back in RUN. Repeat with MUL_LATENCY=1 -> no stall.
- Opcode 0x3F three times -> illegal pulses 3 times, illegal_count=3, ctrl_valid=0. With ILL_CNT_W=2, six illegal opcodes -> count saturates at 3.
- flush during cycle 2 of MUL_BUSY -> stall=0 that cycle; a subsequent STW is decoded to 000011001 on the next accept.
- Assert reset asynchronously mid-MUL_BUSY -> all outputs 0 immediately; after release, BEQ decodes to 010000000 with alu_op=01.
